// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage in front of a combinational instruction memory.
//                Owns the PC, drives the memory byte address, and captures
//                the returned word plus its PC into one output slot that the
//                decoder drains through a valid/ready handshake. Accepts
//                branch redirects from execute and counts completed
//                handshakes for debug.
//
//  Ports       : clk           - system clock, rising edge
//                reset         - synchronous, active-high reset
//                imem_addr     - byte address to instruction memory (= PC)
//                imem_rdata    - little-endian word returned for imem_addr
//                br_taken      - redirect request, sampled on the edge
//                br_target     - redirect byte address (bits [1:0] ignored)
//                out_valid     - output slot holds an instruction
//                out_ready     - decoder takes the slot this cycle
//                out_instr     - instruction in the slot
//                out_pc        - byte address of out_instr
//                out_pc_plus8  - out_pc + 8 (R15 read value), not wrapped
//                fetch_count   - number of completed handshakes
//
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8,
    output logic [31:0] fetch_count
);

    // Keeps any address word aligned and inside the memory window, which
    // implements both the modulo wrap and the forced-zero low bits.
    localparam logic [31:0] c_ADDR_MASK = 32'(IMEM_BYTES - 1) & 32'hFFFF_FFFC;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic [31:0] r_fetch_count;

    logic        w_load;
    logic        w_handshake;
    logic [31:0] w_pc_inc;
    logic [31:0] w_br_pc;

    // The slot may be refilled when it is empty or being drained this cycle.
    assign w_load      = !r_out_valid || out_ready;
    assign w_handshake = r_out_valid && out_ready;
    assign w_pc_inc    = (r_pc + 32'd4) & c_ADDR_MASK;
    assign w_br_pc     = br_target & c_ADDR_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC & c_ADDR_MASK;
            r_out_valid   <= 1'b0;
            r_out_instr   <= 32'd0;
            r_out_pc      <= 32'd0;
            r_fetch_count <= 32'd0;
        end else if (r_state == ST_BOOT) begin
            // One settling cycle: the slot is primed from the reset PC but
            // stays invalid and the PC is not advanced, so the first RUN
            // edge presents the word at RESET_PC as the first valid output.
            r_out_instr <= imem_rdata;
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b0;
            r_state     <= ST_RUN;
        end else begin
            // The consumer took the slot even if a redirect flushes the
            // refill on the same edge, so it still counts.
            if (w_handshake) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (br_taken) begin
                // Flush; the empty slot forces a reload from the target on
                // the next edge, giving a one-cycle bubble.
                r_pc        <= w_br_pc;
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_instr <= imem_rdata;
                r_out_pc    <= r_pc;
                r_out_valid <= 1'b1;
                r_pc        <= w_pc_inc;
            end
        end
    end

    assign imem_addr    = r_pc;
    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_pc       = r_out_pc;
    assign out_pc_plus8 = r_out_pc + 32'd8;
    assign fetch_count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A byte-array
//                instruction memory feeds the DUT; directed scenarios are
//                followed by randomized traffic, all compared against a
//                behavioural model of the fetch slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int c_BYTES = 256;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus8;
    logic [31:0] fetch_count;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (c_BYTES)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus8 (out_pc_plus8),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: byte array, little-endian word reads.
    logic [7:0] mem [c_BYTES];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int b;
        b = int'(a % 32'(c_BYTES));
        return {mem[(b + 3) % c_BYTES], mem[(b + 2) % c_BYTES],
                mem[(b + 1) % c_BYTES], mem[b]};
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    // Behavioural model of the fetch stage.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    logic [31:0] m_cnt;
    logic        m_boot;

    int unsigned n_pass;
    int unsigned n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after.
    task automatic tick(input logic r, input logic b, input logic [31:0] t, input logic rd);
        reset     = r;
        br_taken  = b;
        br_target = t;
        out_ready = rd;
        @(posedge clk);
        if (r) begin
            m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_opc = 32'd0;
            m_cnt = 32'd0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_instr = mem_word(m_pc);
            m_opc   = m_pc;
            m_valid = 1'b0;
            m_boot  = 1'b0;
        end else begin
            if (m_valid && rd) m_cnt = m_cnt + 32'd1;
            if (b) begin
                m_pc    = (t - (t % 32'd4)) % 32'(c_BYTES);
                m_valid = 1'b0;
            end else if (!m_valid || rd) begin
                m_instr = mem_word(m_pc);
                m_opc   = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 32'd4) % 32'(c_BYTES);
            end
        end
        #1;
        chk("imem_addr",    imem_addr,         m_pc);
        chk("out_valid",    32'(out_valid),    32'(m_valid));
        chk("out_instr",    out_instr,         m_instr);
        chk("out_pc",       out_pc,            m_opc);
        chk("out_pc_plus8", out_pc_plus8,      m_opc + 32'd8);
        chk("fetch_count",  fetch_count,       m_cnt);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < c_BYTES; i++) mem[i] = 8'(i);
        {mem[3],  mem[2],  mem[1],  mem[0]}  = 32'hE410_0004;
        {mem[7],  mem[6],  mem[5],  mem[4]}  = 32'hE411_1008;
        {mem[11], mem[10], mem[9],  mem[8]}  = 32'hE412_200C;
        {mem[15], mem[14], mem[13], mem[12]} = 32'hE082_3001;
        reset = 1'b1; br_taken = 1'b0; br_target = 32'd0; out_ready = 1'b0;
        m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_opc = 32'd0;
        m_cnt = 32'd0; m_boot = 1'b1;

        // Reset then free run.
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);                 // BOOT
        chk("boot_valid", 32'(out_valid), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("run_instr0", out_instr, 32'hE410_0004);
        chk("run_addr4",  imem_addr, 32'd4);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("run_instr1", out_instr, 32'hE411_1008);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("run_instr2", out_instr, 32'hE412_200C);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("run_instr3", out_instr, 32'hE082_3001);
        chk("run_plus8",  out_pc_plus8, 32'd20);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("run_count4", fetch_count, 32'd4);

        // Backpressure with out_pc = 8.
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("bp_pc8", out_pc, 32'd8);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0, 1'b0);
        chk("bp_hold_instr", out_instr, 32'hE412_200C);
        chk("bp_hold_addr",  imem_addr, 32'd12);
        chk("bp_hold_count", fetch_count, 32'd2);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("bp_resume_pc", out_pc, 32'd12);
        chk("bp_resume_count", fetch_count, 32'd3);

        // Redirect while out_pc = 4 and the slot is consumed.
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("br_pc4", out_pc, 32'd4);
        tick(1'b0, 1'b1, 32'h31, 1'b1);
        chk("br_bubble", 32'(out_valid), 32'd0);
        chk("br_addr",   imem_addr, 32'h30);
        chk("br_count",  fetch_count, 32'd2);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("br_instr", out_instr, 32'h3332_3130);
        chk("br_opc",   out_pc, 32'h30);

        // Redirect during stall at out_pc = 8.
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b0, 1'b1, 32'h40, 1'b0);
        chk("brs_flush", 32'(out_valid), 32'd0);
        chk("brs_count", fetch_count, 32'd2);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("brs_resume", out_pc, 32'h40);

        // Wrap at the top of memory.
        tick(1'b0, 1'b1, 32'hF8, 1'b1);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_f8", out_pc, 32'hF8);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_fc", out_pc, 32'hFC);
        chk("wrap_addr0", imem_addr, 32'h0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_00", out_pc, 32'h0);

        // Mid-run reset with a valid slot.
        tick(1'b1, 1'b0, 32'd0, 1'b1);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_count", fetch_count, 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("mrst_boot", 32'(out_valid), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b1);
        chk("mrst_first", 32'(out_valid), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
